// File: rtl/draw_trace_multi_if.sv
// Pixel-stream bundle shared by the raster stages: position, sync/blank flags, 12-bit colour.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_trace_multi.sv
// Multi-channel waveform overlay with window border, grid and edge-joining traces.
// Optional double-buffered sample banks are enabled by defining DRAW_TRACE_DBUF_EN.
module draw_trace_multi #(
    parameter int          N_CH      = 2,
    parameter int          SAMPLES   = 256,
    parameter int          DATA_W    = 12,
    parameter logic [10:0] WIN_X0    = 11'd16,
    parameter logic [10:0] WIN_Y0    = 11'd300,
    parameter logic [10:0] WIN_W     = 11'd256,
    parameter logic [10:0] WIN_H     = 11'd256,
    parameter logic [10:0] GRID_STEP = 11'd32,
    parameter logic [47:0] CH_RGB    = {12'hAA0, 12'h0FF, 12'hF0F, 12'h0F0},
    localparam int         AW        = $clog2(SAMPLES),
    localparam int         CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_ch,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              frame_done,
    input  logic [N_CH-1:0]   ch_enable,
    input  logic [AW-1:0]     x_offset,
    input  logic [11:0]       y_offset,
    input  logic [3:0]        scale_shift,
    output logic              bank_sel,
    output logic              swap_pending,
    vga_if.in                 in,
    vga_if.out                out
);
    localparam int HW = ((DATA_W > 12) ? DATA_W : 12) + 2;
    localparam int TW = 26;
`ifdef DRAW_TRACE_DBUF_EN
    localparam int RAW = AW + 1;
`else
    localparam int RAW = AW;
`endif
    localparam int DEPTH = 1 << RAW;
    localparam logic signed [11:0]   X0_S   = $signed({1'b0, WIN_X0});
    localparam logic signed [11:0]   Y0_S   = $signed({1'b0, WIN_Y0});
    localparam logic signed [11:0]   W_S    = $signed({1'b0, WIN_W});
    localparam logic signed [11:0]   H_S    = $signed({1'b0, WIN_H});
    localparam logic [11:0]          G_MASK = {1'b0, GRID_STEP - 11'd1};
    localparam logic signed [HW-1:0] H_MAX  = {{(HW-11){1'b0}}, WIN_H};

    logic [DATA_W-1:0]     ram_q [N_CH][DEPTH];
    logic [RAW-1:0]        rd_addr, wr_addr_full;
    logic signed [11:0]    col0, col1_d, col1_q, col2_d, col2_q, row2;
    logic [AW-1:0]         idx0;
    logic [DATA_W-1:0]     rdata_d [N_CH];
    logic [DATA_W-1:0]     rdata_q [N_CH];
    logic signed [HW-1:0]  hs [N_CH];
    logic [11:0]           h2_d [N_CH];
    logic [11:0]           h2_q [N_CH];
    logic [11:0]           hp2_d [N_CH];
    logic [11:0]           hp2_q [N_CH];
    logic [TW-1:0]         tim1_d, tim1_q, tim2_d, tim2_q, tim3_d, tim3_q;
    logic [11:0]           rgb1_d, rgb1_q, rgb2_d, rgb2_q, rgb3_d, rgb3_q, trace_rgb;
    logic [N_CH-1:0]       hit;
    logic                  in_win, on_border, on_grid;

    // Stage 1: window-relative column, panned sample index and parallel RAM read.
    always_comb begin
        col0   = $signed({1'b0, in.hcount}) - X0_S;
        idx0   = col0[AW-1:0] + x_offset;
        col1_d = col0;
        tim1_d = {in.hsync, in.vsync, in.hblnk, in.vblnk, in.hcount, in.vcount};
        rgb1_d = in.rgb;
        for (int c = 0; c < N_CH; c++) begin
            rdata_d[c] = ram_q[c][rd_addr];
        end
    end

    // Stage 2: scaled, offset and clamped trace height plus the previous column's height.
    always_comb begin
        col2_d = col1_q;
        tim2_d = tim1_q;
        rgb2_d = rgb1_q;
        for (int c = 0; c < N_CH; c++) begin
            hs[c] = $signed({{(HW-DATA_W){1'b0}}, rdata_q[c] >> scale_shift})
                  + $signed({{(HW-12){y_offset[11]}}, y_offset});
            if (hs[c][HW-1]) begin
                h2_d[c] = 12'd0;
            end else if (hs[c] > H_MAX) begin
                h2_d[c] = {1'b0, WIN_H};
            end else begin
                h2_d[c] = hs[c][11:0];
            end
            // The first window column has no left neighbour, so it collapses to a point.
            if (col1_q == 12'sd0) begin
                hp2_d[c] = h2_d[c];
            end else begin
                hp2_d[c] = h2_q[c];
            end
        end
    end

    // Stage 3: hit tests and colour priority border > trace > grid > passthrough.
    always_comb begin
        tim3_d    = tim2_q;
        row2      = Y0_S - $signed({1'b0, tim2_q[10:0]});
        in_win    = (col2_q >= 12'sd0) && (col2_q <= W_S) && (row2 >= 12'sd0) && (row2 <= H_S);
        on_border = in_win && ((col2_q == 12'sd0) || (col2_q == W_S) ||
                               (row2 == 12'sd0) || (row2 == H_S));
        on_grid   = in_win && ((($unsigned(col2_q) & G_MASK) == 12'd0) ||
                               (($unsigned(row2) & G_MASK) == 12'd0));
        trace_rgb = 12'h000;
        for (int c = N_CH - 1; c >= 0; c--) begin
            hit[c] = ch_enable[c] && in_win &&
                     ((($unsigned(row2) >= h2_q[c]) && ($unsigned(row2) <= hp2_q[c])) ||
                      (($unsigned(row2) >= hp2_q[c]) && ($unsigned(row2) <= h2_q[c])));
            if (hit[c]) begin
                trace_rgb = CH_RGB[c*12 +: 12];
            end else begin
                trace_rgb = trace_rgb;
            end
        end
        if (on_border) begin
            rgb3_d = 12'hFFF;
        end else if (|hit) begin
            rgb3_d = trace_rgb;
        end else if (on_grid) begin
            rgb3_d = 12'h888;
        end else begin
            rgb3_d = rgb2_q;
        end
    end

    // Pipeline registers; clearing every stage makes out.* read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col1_q <= 12'sd0;
            col2_q <= 12'sd0;
            tim1_q <= '0;
            tim2_q <= '0;
            tim3_q <= '0;
            rgb1_q <= 12'h000;
            rgb2_q <= 12'h000;
            rgb3_q <= 12'h000;
            for (int c = 0; c < N_CH; c++) begin
                rdata_q[c] <= '0;
                h2_q[c]    <= 12'd0;
                hp2_q[c]   <= 12'd0;
            end
        end else begin
            col1_q <= col1_d;
            col2_q <= col2_d;
            tim1_q <= tim1_d;
            tim2_q <= tim2_d;
            tim3_q <= tim3_d;
            rgb1_q <= rgb1_d;
            rgb2_q <= rgb2_d;
            rgb3_q <= rgb3_d;
            for (int c = 0; c < N_CH; c++) begin
                rdata_q[c] <= rdata_d[c];
                h2_q[c]    <= h2_d[c];
                hp2_q[c]   <= hp2_d[c];
            end
        end
    end

    // Sample memory is left unreset; a same-cycle read of the written word sees old data.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_ch) < N_CH)) begin
            ram_q[wr_ch][wr_addr_full] <= wr_data;
        end
    end

    assign {out.hsync, out.vsync, out.hblnk, out.vblnk, out.hcount, out.vcount} = tim3_q;
    assign out.rgb = rgb3_q;

`ifdef DRAW_TRACE_DBUF_EN
    logic bank_sel_d, bank_sel_q, swap_pending_d, swap_pending_q, vblnk_d, vblnk_q, swap_s;

    // A pending swap is taken on the next vblank rising edge; pulses while pending are absorbed.
    always_comb begin
        vblnk_d    = in.vblnk;
        swap_s     = in.vblnk && !vblnk_q && swap_pending_q;
        bank_sel_d = bank_sel_q ^ swap_s;
        if (swap_s) begin
            swap_pending_d = 1'b0;
        end else begin
            swap_pending_d = swap_pending_q | frame_done;
        end
    end

    // Bank control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            vblnk_q        <= 1'b0;
        end else begin
            bank_sel_q     <= bank_sel_d;
            swap_pending_q <= swap_pending_d;
            vblnk_q        <= vblnk_d;
        end
    end

    assign bank_sel     = bank_sel_q;
    assign swap_pending = swap_pending_q;
    assign rd_addr      = {bank_sel_q, idx0};
    assign wr_addr_full = {~bank_sel_q, wr_addr};
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
    assign bank_sel          = 1'b0;
    assign swap_pending      = 1'b0;
    assign rd_addr           = idx0;
    assign wr_addr_full      = wr_addr;
`endif
endmodule

// File: tb/tb_draw_trace_multi.sv
// Self-checking bench for draw_trace_multi: directed scans plus randomized scans against a pixel model.
module tb_draw_trace_multi;
    localparam int NS = 256;
    localparam logic [47:0] COLOURS = {12'hAA0, 12'h0FF, 12'hF0F, 12'h0F0};

    typedef struct packed {
        logic [11:0] rgb;
        logic [25:0] tim;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [0:0]  wr_ch;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;
    logic        frame_done;
    logic [1:0]  ch_enable;
    logic [7:0]  x_offset;
    logic [11:0] y_offset;
    logic [3:0]  scale_shift;
    logic        bank_sel;
    logic        swap_pending;

    vga_if vin();
    vga_if vout();

    draw_trace_multi dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .ch_enable(ch_enable),
        .x_offset(x_offset), .y_offset(y_offset), .scale_shift(scale_shift),
        .bank_sel(bank_sel), .swap_pending(swap_pending), .in(vin), .out(vout)
    );

    always #5 clk = ~clk;

    int   mem [2][NS];
    int   prev_h [2];
    pix_t expq [$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Height of channel c at window column col, straight from the display rules.
    function automatic int trace_h(input int c, input int col);
        int v;
        v = (mem[c][(col + int'(x_offset)) & (NS - 1)] >> scale_shift) + int'($signed(y_offset));
        if (v < 0) return 0;
        if (v > 256) return 256;
        return v;
    endfunction

    task automatic prime_after_reset();
        pix_t z;
        z = '0;
        expq.delete();
        expq.push_back(z);
        expq.push_back(z);
        prev_h[0] = 0;
        prev_h[1] = 0;
    endtask

    // One pixel clock: apply inputs, predict the pixel, compare the one issued three clocks ago.
    task automatic drive(input int hc, input int vc, input bit we, input int wch, input int wa, input int wd);
        pix_t e;
        int   col, row, hn [2], hp, lo, hi;
        bit   inwin, hit_found;
        logic [11:0] trc;
        vin.hcount = 11'(hc);
        vin.vcount = 11'(vc);
        vin.rgb    = 12'($urandom);
        {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk} = 4'($urandom);
        wr_en   = we;
        wr_ch   = 1'(wch);
        wr_addr = 8'(wa);
        wr_data = 12'(wd);
        col   = hc - 16;
        row   = 300 - vc;
        inwin = (col >= 0) && (col <= 256) && (row >= 0) && (row <= 256);
        hit_found = 1'b0;
        trc = 12'h000;
        for (int c = 0; c < 2; c++) begin
            hn[c] = trace_h(c, col);
            hp = (col == 0) ? hn[c] : prev_h[c];
            lo = (hn[c] < hp) ? hn[c] : hp;
            hi = (hn[c] < hp) ? hp : hn[c];
            if (!hit_found && ch_enable[c] && inwin && row >= lo && row <= hi) begin
                trc = COLOURS[c*12 +: 12];
                hit_found = 1'b1;
            end
        end
        if (inwin && (col == 0 || col == 256 || row == 0 || row == 256)) e.rgb = 12'hFFF;
        else if (hit_found) e.rgb = trc;
        else if (inwin && (col % 32 == 0 || row % 32 == 0)) e.rgb = 12'h888;
        else e.rgb = vin.rgb;
        e.tim = {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.hcount, vin.vcount};
        expq.push_back(e);
        prev_h[0] = hn[0];
        prev_h[1] = hn[1];
        if (we) mem[wch][wa] = wd;
        @(posedge clk);
        #1;
        if (expq.size() == 3) begin
            e = expq.pop_front();
            check("rgb", 64'(vout.rgb), 64'(e.rgb));
            check("timing", 64'({vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.hcount, vout.vcount}),
                  64'(e.tim));
        end
    endtask

    task automatic write_word(input int ch, input int a, input int d);
        drive(0, 0, 1'b1, ch, a, d);
    endtask

    // One raster line across the window, optionally with random writes mixed in.
    task automatic scan(input int vc, input bit with_writes);
        int a;
        for (int hc = 10; hc <= 282; hc++) begin
            if (with_writes && $urandom_range(3) == 0) begin
                a = ($urandom_range(1) == 0) ? ((hc - 16 + int'(x_offset)) & (NS - 1)) : int'($urandom_range(NS - 1));
                drive(hc, vc, 1'b1, int'($urandom_range(1)), a, int'($urandom_range(4095)));
            end else begin
                drive(hc, vc, 1'b0, 0, 0, 0);
            end
        end
        drive(0, 0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int col, row;
        rst_n = 1'b1;
        wr_en = 1'b0; wr_ch = 1'b0; wr_addr = 8'd0; wr_data = 12'd0; frame_done = 1'b0;
        ch_enable = 2'b01; x_offset = 8'd0; y_offset = 12'd0; scale_shift = 4'd1;
        vin.hcount = 11'd0; vin.vcount = 11'd0; vin.rgb = 12'h123;
        {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk} = 4'b1111;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 64'({vout.rgb, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 64'd0);
        check("reset_bank", 64'({bank_sel, swap_pending}), 64'd0);
        rst_n = 1'b1;
        prime_after_reset();

        // Flat trace on channel 0, random channel 1 (disabled).
        for (int a = 0; a < NS; a++) write_word(0, a, 256);
        for (int a = 0; a < NS; a++) write_word(1, a, int'($urandom_range(4095)));
        scan(172, 1'b0);
        scan(171, 1'b0);
        scan(300, 1'b0);
        scan(44, 1'b0);

        // Mid-line asynchronous reset, then tracking resumes three clocks later.
        for (int hc = 10; hc < 150; hc++) drive(hc, 172, 1'b0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check("midline_reset", 64'({vout.rgb, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        prime_after_reset();
        scan(172, 1'b0);

        // Step edge joined by a vertical segment.
        scale_shift = 4'd0;
        write_word(0, 98, 0);
        write_word(0, 99, 0);
        write_word(0, 100, 200);
        scan(299, 1'b0);
        scan(200, 1'b0);
        scan(100, 1'b0);
        scan(99, 1'b0);

        // Pan wrap and clamping of a negative height.
        x_offset = 8'd250;
        write_word(0, 4, 64);
        scan(236, 1'b0);
        y_offset = 12'hF9C;
        scan(299, 1'b0);
        scan(200, 1'b0);

        // Identical channels: channel 0 wins; trace on a grid row beats grid.
        x_offset = 8'd0; y_offset = 12'd0; scale_shift = 4'd1; ch_enable = 2'b11;
        for (int a = 0; a < NS; a++) write_word(1, a, mem[0][a]);
        scan(172, 1'b0);
        scan(236, 1'b0);

        // Single-bank build ignores frame_done.
        frame_done = 1'b1;
        drive(0, 0, 1'b0, 0, 0, 0);
        frame_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1'b0, 0, 0, 0);
            check("bank_tied", 64'({bank_sel, swap_pending}), 64'd0);
        end

        // Randomized content, configuration and rows, with interleaved writes.
        for (int a = 0; a < NS; a++) write_word(0, a, int'($urandom_range(4095)));
        for (int a = 0; a < NS; a++) write_word(1, a, int'($urandom_range(4095)));
        for (int n = 0; n < 20; n++) begin
            x_offset    = 8'($urandom);
            y_offset    = 12'($signed(int'($urandom_range(600)) - 300));
            scale_shift = 4'($urandom_range(4));
            ch_enable   = 2'($urandom);
            col = int'($urandom_range(256));
            row = trace_h(int'($urandom_range(1)), col) + int'($urandom_range(4)) - 2;
            if ($urandom_range(3) == 0) row = int'($urandom_range(290)) - 20;
            scan(300 - row, 1'b1);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 1'b0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
